// File: rtl/regwrite_trace_pkg.sv
// Shared definitions for the register-write trace buffer: FSM state
// encodings and the packed entry width helper.
package regwrite_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
   } trace_state_t;

   // An entry is {cycle stamp, register index, write data}, packed MSB first.
   function automatic int entry_width(input int cycle_w, input int reg_w, input int data_w);
      return cycle_w + reg_w + data_w;
   endfunction

endpackage

// File: rtl/regwrite_trace_buffer_fifo.sv
// Circular trace storage: push, pop and overwrite-oldest, with registered
// storage and a combinational read of the head entry.
module trace_fifo #(
   parameter int WIDTH = 47,
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     overwrite,
   input  logic [WIDTH-1:0]         push_data,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     lost
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             do_pop;
   logic             do_write;
   logic             do_evict;

   // A pop only happens when something is held; a push into a full buffer
   // either rides along with a pop, evicts the oldest entry, or is lost.
   always_comb begin
      full     = (count == CNT_W'(DEPTH));
      do_pop   = pop && (count != '0);
      do_write = push && (!full || do_pop || overwrite);
      do_evict = push && full && !do_pop && overwrite;
      lost     = push && full && !do_pop;
      head     = mem[rd_ptr];
   end

   // Storage array has no reset; stale contents are never visible because
   // the count gates validity.
   always_ff @(posedge clock) begin
      if (do_write) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_write) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop || do_evict) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (do_write && !do_pop && !do_evict) begin
            count <= count + CNT_W'(1);
         end else if (do_pop && !do_write) begin
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/regwrite_trace_buffer.sv
// Captures register-file writes (excluding r0) during a bounded window,
// stamping each with its cycle offset, and offers them oldest-first on a
// valid/ready read port.
module regwrite_trace_buffer
   import regwrite_trace_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CYCLE_WIDTH    = 10,
   parameter int DEPTH          = 16,
   parameter int MAX_CYCLES     = 255
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       ctrl_writeEnable,
   input  logic [REG_ADDR_WIDTH-1:0]  ctrl_writeReg,
   input  logic [DATA_WIDTH-1:0]      data_writeReg,
   input  logic                       start,
   input  logic                       wrap_mode,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [CYCLE_WIDTH-1:0]     rd_cycle,
   output logic [REG_ADDR_WIDTH-1:0]  rd_reg,
   output logic [DATA_WIDTH-1:0]      rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       done
);

   localparam int ENTRY_W = entry_width(CYCLE_WIDTH, REG_ADDR_WIDTH, DATA_WIDTH);

   trace_state_t            state;
   trace_state_t            next_state;
   logic [CYCLE_WIDTH-1:0]  cycle_cnt;
   logic                    capture_start;
   logic                    event_hit;
   logic                    last_cycle;
   logic                    lost;
   logic [ENTRY_W-1:0]      head;

   // Start is only honoured outside CAPTURE; r0 writes are never traced.
   always_comb begin
      capture_start = start && (state != ST_CAPTURE);
      event_hit     = (state == ST_CAPTURE) && ctrl_writeEnable && (ctrl_writeReg != '0);
      last_cycle    = (cycle_cnt == CYCLE_WIDTH'(MAX_CYCLES - 1));
   end

   // Next-state logic for the capture window.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:    if (start) next_state = ST_CAPTURE;
         ST_CAPTURE: if (last_cycle) next_state = ST_DONE;
         ST_DONE:    if (start) next_state = ST_CAPTURE;
         default:    next_state = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Cycle stamp: zero on the first CAPTURE cycle, held once the window closes.
   always_ff @(posedge clock) begin
      if (reset || capture_start) begin
         cycle_cnt <= '0;
      end else if (state == ST_CAPTURE && !last_cycle) begin
         cycle_cnt <= cycle_cnt + CYCLE_WIDTH'(1);
      end
   end

   // Sticky flag for any event that was dropped or evicted an older one.
   always_ff @(posedge clock) begin
      if (reset || capture_start) begin
         overflow <= 1'b0;
      end else if (lost) begin
         overflow <= 1'b1;
      end
   end

   trace_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .clear     (capture_start),
      .push      (event_hit),
      .pop       (rd_ready),
      .overwrite (wrap_mode),
      .push_data ({cycle_cnt, ctrl_writeReg, data_writeReg}),
      .head      (head),
      .count     (count),
      .lost      (lost)
   );

   // Read port and status outputs derived from the fifo and FSM.
   always_comb begin
      rd_valid                   = (count != '0);
      done                       = (state == ST_DONE);
      {rd_cycle, rd_reg, rd_data} = head;
   end

endmodule

// File: tb/tb_regwrite_trace_buffer.sv
// Scoreboard bench for regwrite_trace_buffer: directed writes push their
// hand-computed trace entries into a queue, and a monitor compares every
// pop the DUT performs against the queue front.
module tb_regwrite_trace_buffer;

   localparam int DW    = 32;
   localparam int RW    = 5;
   localparam int CW    = 10;
   localparam int DEPTH = 4;
   localparam int MAXC  = 8;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [CW-1:0] cyc;
      logic [RW-1:0] rg;
      logic [DW-1:0] data;
   } entry_t;

   logic             clock;
   logic             reset;
   logic             ctrl_writeEnable;
   logic [RW-1:0]    ctrl_writeReg;
   logic [DW-1:0]    data_writeReg;
   logic             start;
   logic             wrap_mode;
   logic             rd_valid;
   logic             rd_ready;
   logic [CW-1:0]    rd_cycle;
   logic [RW-1:0]    rd_reg;
   logic [DW-1:0]    rd_data;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             done;

   entry_t exp_q[$];
   entry_t mon_exp;
   int     checks = 0;
   int     errors = 0;

   regwrite_trace_buffer #(
      .DATA_WIDTH     (DW),
      .REG_ADDR_WIDTH (RW),
      .CYCLE_WIDTH    (CW),
      .DEPTH          (DEPTH),
      .MAX_CYCLES     (MAXC)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .start            (start),
      .wrap_mode        (wrap_mode),
      .rd_valid         (rd_valid),
      .rd_ready         (rd_ready),
      .rd_cycle         (rd_cycle),
      .rd_reg           (rd_reg),
      .rd_data          (rd_data),
      .count            (count),
      .overflow         (overflow),
      .done             (done)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Monitor: every accepted pop must match the oldest expected entry.
   always @(negedge clock) begin
      if (!reset && rd_valid && rd_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_pop: got cyc=%0d reg=%0d data=%0d, required no entry",
                     rd_cycle, rd_reg, rd_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({rd_cycle, rd_reg, rd_data} !== mon_exp) begin
               errors++;
               $display("[TB] FAIL pop_entry: got cyc=%0d reg=%0d data=%0d, required cyc=%0d reg=%0d data=%0d",
                        rd_cycle, rd_reg, rd_data, mon_exp.cyc, mon_exp.rg, mon_exp.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input logic we, input int rg, input int data, input logic ready);
      ctrl_writeEnable = we;
      ctrl_writeReg    = RW'(rg);
      data_writeReg    = DW'(data);
      rd_ready         = ready;
      tick();
   endtask

   task automatic expect_entry(input int cyc, input int rg, input int data);
      entry_t e;
      e.cyc  = CW'(cyc);
      e.rg   = RW'(rg);
      e.data = DW'(data);
      exp_q.push_back(e);
   endtask

   task automatic begin_capture();
      ctrl_writeEnable = 1'b0;
      rd_ready         = 1'b0;
      start            = 1'b1;
      exp_q.delete();
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 30 && !done; i++) begin
         apply_stimulus(1'b0, 0, 0, 1'b0);
      end
      check_output("done_reached", done, 1);
   endtask

   task automatic drain();
      ctrl_writeEnable = 1'b0;
      rd_ready = 1'b1;
      for (int i = 0; i < 2 * DEPTH + 2 && rd_valid; i++) begin
         tick();
      end
      rd_ready = 1'b0;
      check_output("drained_count", count, 0);
   endtask

   task automatic pop_n(input int n);
      ctrl_writeEnable = 1'b0;
      rd_ready = 1'b1;
      repeat (n) tick();
      rd_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      wrap_mode = 1'b0;
      ctrl_writeEnable = 1'b0;
      ctrl_writeReg = '0;
      data_writeReg = '0;
      rd_ready = 1'b0;
      tick();
      tick();
      check_output("reset_count", count, 0);
      check_output("reset_rd_valid", rd_valid, 0);
      check_output("reset_overflow", overflow, 0);
      check_output("reset_done", done, 0);
      reset = 1'b0;
      tick();

      // r5=7 at cycle 2 is traced, r0=9 at cycle 3 is not
      $display("[TB] single write and r0 filter");
      begin_capture();
      expect_entry(2, 5, 7);
      apply_stimulus(1'b0, 0, 0, 1'b0);
      apply_stimulus(1'b0, 0, 0, 1'b0);
      apply_stimulus(1'b1, 5, 7, 1'b0);
      apply_stimulus(1'b1, 0, 9, 1'b0);
      check_output("single_count", count, 1);
      wait_done();
      drain();

      // stop-when-full keeps the first four writes
      $display("[TB] full buffer, wrap_mode=0");
      begin_capture();
      wrap_mode = 1'b0;
      for (int k = 0; k < 4; k++) expect_entry(k, k + 1, 10 * (k + 1));
      for (int k = 0; k < 6; k++) apply_stimulus(1'b1, k + 1, 10 * (k + 1), 1'b0);
      apply_stimulus(1'b0, 0, 0, 1'b0);
      check_output("stop_count", count, 4);
      check_output("stop_overflow", overflow, 1);
      check_output("stop_head_reg", rd_reg, 1);
      drain();
      wait_done();
      check_output("overflow_sticky", overflow, 1);

      // overwrite mode keeps the last four writes; restart clears overflow
      $display("[TB] full buffer, wrap_mode=1");
      begin_capture();
      check_output("restart_overflow", overflow, 0);
      wrap_mode = 1'b1;
      for (int k = 2; k < 6; k++) expect_entry(k, k + 1, 10 * (k + 1));
      for (int k = 0; k < 6; k++) apply_stimulus(1'b1, k + 1, 10 * (k + 1), 1'b0);
      apply_stimulus(1'b0, 0, 0, 1'b0);
      check_output("wrap_count", count, 4);
      check_output("wrap_overflow", overflow, 1);
      pop_n(3);
      wait_done();
      check_output("partial_count", count, 1);
      check_output("partial_head_reg", rd_reg, 6);

      // simultaneous push and pop on a full buffer; restart clears count
      $display("[TB] full buffer push with pop");
      begin_capture();
      check_output("restart_count", count, 0);
      check_output("restart_rd_valid", rd_valid, 0);
      check_output("restart_done", done, 0);
      wrap_mode = 1'b0;
      for (int k = 0; k < 4; k++) expect_entry(k, k + 1, 10 * (k + 1));
      expect_entry(4, 7, 70);
      for (int k = 0; k < 4; k++) apply_stimulus(1'b1, k + 1, 10 * (k + 1), 1'b0);
      check_output("prepop_count", count, 4);
      apply_stimulus(1'b1, 7, 70, 1'b1);
      check_output("pushpop_count", count, 4);
      check_output("pushpop_overflow", overflow, 0);
      drain();
      check_output("pushpop_rd_valid", rd_valid, 0);
      wait_done();

      // window of MAXC cycles with a write every cycle and continuous reads
      $display("[TB] capture window boundary");
      begin_capture();
      for (int k = 0; k < MAXC; k++) expect_entry(k, 1, 100 + k);
      for (int k = 0; k < MAXC + 3; k++) begin
         apply_stimulus(1'b1, 1, 100 + k, 1'b1);
         if (k == MAXC - 2) check_output("done_before_end", done, 0);
         if (k == MAXC - 1) check_output("done_at_end", done, 1);
      end
      apply_stimulus(1'b0, 0, 0, 1'b0);
      check_output("window_count", count, 0);
      check_output("window_all_popped", exp_q.size(), 0);

      // reset in cycle 4 of capture with three entries held
      $display("[TB] reset during capture");
      begin_capture();
      apply_stimulus(1'b1, 1, 11, 1'b0);
      apply_stimulus(1'b1, 2, 22, 1'b0);
      apply_stimulus(1'b1, 3, 33, 1'b0);
      apply_stimulus(1'b0, 0, 0, 1'b0);
      check_output("prereset_count", count, 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      check_output("midreset_count", count, 0);
      check_output("midreset_rd_valid", rd_valid, 0);
      check_output("midreset_done", done, 0);
      check_output("midreset_overflow", overflow, 0);
      apply_stimulus(1'b1, 2, 5, 1'b0);
      apply_stimulus(1'b1, 2, 6, 1'b0);
      check_output("idle_no_capture", count, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
